// File: rtl/alarm_set_controller.sv
// Alarm time editor: key edge detect, field select, up-key auto-repeat,
// and alarm match/ring timing.
module alarm_set_controller #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int RING_SECS     = 60,
    parameter int RST_HOUR      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       edit_en,
    input  logic       alarm_en,
    input  logic       left_key,
    input  logic       right_key,
    input  logic       up_key,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [5:0] alarm_sec,
    output logic [1:0] field,
    output logic       ringing
);
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int RW   = $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {
        F_SEC  = 2'd0,
        F_MIN  = 2'd1,
        F_HOUR = 2'd2
    } field_e;

    field_e          field_q, field_d;
    logic [4:0]      hour_q, hour_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic            left_q, right_q, up_q;
    logic            rpt_on_q, rpt_on_d;
    logic            rpt_ph_q, rpt_ph_d;
    logic [CW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic            match_q;
    logic            ringing_q, ringing_d;
    logic [RW-1:0]   ring_cnt_q, ring_cnt_d;

    logic            left_e, right_e, up_e, any_e;
    logic            field_chg, rpt_hit, rpt_fire, inc;
    logic            match, ring_set, ring_clr;
    logic [RW-1:0]   ring_nxt;

    always_comb begin
        left_e  = left_key & ~left_q;
        right_e = right_key & ~right_q;
        up_e    = up_key & ~up_q;
        any_e   = left_e | right_e | up_e;

        field_d = field_q;
        if (edit_en && left_e && !right_e) begin
            unique case (field_q)
                F_SEC:   field_d = F_MIN;
                default: field_d = F_HOUR;
            endcase
        end else if (edit_en && right_e && !left_e) begin
            unique case (field_q)
                F_HOUR:  field_d = F_MIN;
                default: field_d = F_SEC;
            endcase
        end
        field_chg = (field_d != field_q);

        // Phase 0 waits out the initial hold, phase 1 paces the repeats
        rpt_hit  = rpt_ph_q ? (rpt_cnt_q == CW'(REPEAT_CYCLES))
                            : (rpt_cnt_q == CW'(HOLD_CYCLES));
        rpt_fire = rpt_on_q & up_key & edit_en & ~field_chg & rpt_hit;
        inc      = edit_en & (up_e | rpt_fire);

        rpt_on_d  = 1'b0;
        rpt_ph_d  = 1'b0;
        rpt_cnt_d = '0;
        if (edit_en && up_key && !field_chg) begin
            if (up_e) begin
                rpt_on_d  = 1'b1;
                rpt_cnt_d = CW'(1);
            end else if (rpt_on_q) begin
                rpt_on_d = 1'b1;
                if (rpt_hit) begin
                    rpt_ph_d  = 1'b1;
                    rpt_cnt_d = CW'(1);
                end else begin
                    rpt_ph_d  = rpt_ph_q;
                    rpt_cnt_d = rpt_cnt_q + CW'(1);
                end
            end
        end

        // Increment targets the field held before any same-cycle move
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (inc) begin
            unique case (field_q)
                F_HOUR:  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                F_MIN:   min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                default: sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            endcase
        end

        match    = (cur_hour == hour_q) && (cur_min == min_q) && (cur_sec == sec_q);
        ring_nxt = ring_cnt_q + RW'(1);
        ring_set = match & ~match_q & alarm_en & ~edit_en;
        ring_clr = any_e | ~alarm_en | edit_en |
                   (ringing_q & tick_1hz & (ring_nxt == RW'(RING_SECS)));

        ringing_d  = ring_clr ? 1'b0 : (ring_set | ringing_q);
        ring_cnt_d = ring_cnt_q;
        if (!ringing_d)
            ring_cnt_d = '0;
        else if (ringing_q && tick_1hz)
            ring_cnt_d = ring_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_q    <= F_SEC;
            hour_q     <= 5'(RST_HOUR);
            min_q      <= '0;
            sec_q      <= '0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            up_q       <= 1'b0;
            rpt_on_q   <= 1'b0;
            rpt_ph_q   <= 1'b0;
            rpt_cnt_q  <= '0;
            match_q    <= 1'b0;
            ringing_q  <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            field_q    <= field_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            left_q     <= left_key;
            right_q    <= right_key;
            up_q       <= up_key;
            rpt_on_q   <= rpt_on_d;
            rpt_ph_q   <= rpt_ph_d;
            rpt_cnt_q  <= rpt_cnt_d;
            match_q    <= match;
            ringing_q  <= ringing_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign alarm_hour = hour_q;
    assign alarm_min  = min_q;
    assign alarm_sec  = sec_q;
    assign field      = field_q;
    assign ringing    = ringing_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Directed bench for alarm_set_controller with short hold/repeat/ring
// parameters and hand-computed expectations.
module tb_alarm_set_controller;
    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       edit_en;
    logic       alarm_en;
    logic       left_key;
    logic       right_key;
    logic       up_key;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] alarm_sec;
    logic [1:0] field;
    logic       ringing;

    int checks = 0;
    int errors = 0;

    alarm_set_controller #(
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(5),
        .RING_SECS    (3),
        .RST_HOUR     (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .edit_en   (edit_en),
        .alarm_en  (alarm_en),
        .left_key  (left_key),
        .right_key (right_key),
        .up_key    (up_key),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_sec (alarm_sec),
        .field     (field),
        .ringing   (ringing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // k: 0=left 1=right 2=up; key held for one sampled edge
    task automatic press(input int k);
        case (k)
            0: left_key = 1'b1;
            1: right_key = 1'b1;
            default: up_key = 1'b1;
        endcase
        step();
    endtask

    task automatic release_keys();
        left_key  = 1'b0;
        right_key = 1'b0;
        up_key    = 1'b0;
        step();
    endtask

    initial begin
        int exp_h;
        reset = 1'b1; tick_1hz = 1'b0; edit_en = 1'b0; alarm_en = 1'b0;
        left_key = 1'b0; right_key = 1'b0; up_key = 1'b0;
        cur_hour = '0; cur_min = '0; cur_sec = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_hour", 32'(alarm_hour), 6);
        chk("rst_min", 32'(alarm_min), 0);
        chk("rst_sec", 32'(alarm_sec), 0);
        chk("rst_field", 32'(field), 0);
        chk("rst_ring", 32'(ringing), 0);
        step(); step();
        reset = 1'b1;
        step();
        edit_en = 1'b1;
        step();

        press(0); chk("left1", 32'(field), 1); release_keys();
        press(0); chk("left2", 32'(field), 2); release_keys();
        press(0); chk("left3_sat", 32'(field), 2); release_keys();
        left_key = 1'b1; right_key = 1'b1; step();
        chk("left_right_same", 32'(field), 2);
        release_keys();

        press(1); chk("right1", 32'(field), 1); release_keys();
        press(1); chk("right2", 32'(field), 0); release_keys();
        press(1); chk("right_sat", 32'(field), 0); release_keys();

        for (int i = 0; i < 59; i++) begin
            press(2); release_keys();
        end
        chk("sec_59", 32'(alarm_sec), 59);
        press(2);
        chk("sec_wrap", 32'(alarm_sec), 0);
        chk("sec_wrap_min", 32'(alarm_min), 0);
        release_keys();

        press(0); release_keys();
        press(0); release_keys();
        chk("to_hour", 32'(field), 2);
        for (int i = 0; i < 17; i++) begin
            press(2); release_keys();
        end
        chk("hour_23", 32'(alarm_hour), 23);
        press(2);
        chk("hour_wrap", 32'(alarm_hour), 0);
        chk("hour_wrap_min", 32'(alarm_min), 0);
        chk("hour_wrap_sec", 32'(alarm_sec), 0);
        release_keys();

        // Hold up for 40 sampled edges; increments at 1, 21, 26, 31, 36
        exp_h = 0;
        up_key = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1 || i == 21 || i == 26 || i == 31 || i == 36)
                exp_h++;
            chk($sformatf("rpt_c%0d", i), 32'(alarm_hour), 32'(exp_h));
        end
        release_keys();
        step(); step();
        chk("rpt_total", 32'(alarm_hour), 5);

        edit_en = 1'b0;
        step();
        press(0); release_keys();
        press(2); release_keys();
        chk("noedit_field", 32'(field), 2);
        chk("noedit_hour", 32'(alarm_hour), 5);

        edit_en = 1'b1;
        step();
        press(2); release_keys();
        chk("set_hour6", 32'(alarm_hour), 6);
        press(1); release_keys();
        press(1); release_keys();
        chk("set_field_sec", 32'(field), 0);
        for (int i = 0; i < 5; i++) begin
            press(2); release_keys();
        end
        chk("set_sec5", 32'(alarm_sec), 5);
        chk("set_min0", 32'(alarm_min), 0);

        edit_en = 1'b0;
        cur_hour = 5'd6; cur_min = 6'd0; cur_sec = 6'd4;
        alarm_en = 1'b1;
        step(); step();
        chk("no_ring_before", 32'(ringing), 0);
        cur_sec = 6'd5;
        #1;
        chk("ring_not_yet", 32'(ringing), 0);
        step();
        chk("ring_set", 32'(ringing), 1);
        for (int t = 1; t <= 3; t++) begin
            tick_1hz = 1'b1; step();
            tick_1hz = 1'b0;
            chk($sformatf("ring_tick%0d", t), 32'(ringing), (t < 3) ? 1 : 0);
            step();
        end

        cur_sec = 6'd4; step();
        cur_sec = 6'd5; step();
        chk("ring_set2", 32'(ringing), 1);
        press(1);
        chk("ring_key_clr", 32'(ringing), 0);
        release_keys();
        chk("ring_key_field", 32'(field), 0);

        alarm_en = 1'b0; step();
        alarm_en = 1'b1; step(); step();
        chk("arm_on_match", 32'(ringing), 0);

        cur_sec = 6'd4; step();
        cur_sec = 6'd5; step();
        chk("ring_set3", 32'(ringing), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ring", 32'(ringing), 0);
        chk("midrst_hour", 32'(alarm_hour), 6);
        chk("midrst_sec", 32'(alarm_sec), 0);
        chk("midrst_field", 32'(field), 0);
        step();
        reset = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
